// File: rtl/calc_key_parser.sv
// Calculator keystroke parser: turns ASCII key bytes into operands, opcode and entry state.
// Optional CALC_ECHO_EN macro adds a one-entry echo buffer (tx_data/tx_valid/tx_ready).
module calc_key_parser #(
   parameter int DATA_W     = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [3:0]        opcode,
   output logic [1:0]        state,
   output logic              calc_go,
   output logic              div0
`ifdef CALC_ECHO_EN
   ,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
`endif
);

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      RESULT  = 2'd2,
      ERROR   = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam int EXT_W = DATA_W + 4;
   localparam logic [3:0] OP_DIV = 4'd3;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] op_a_reg, op_a_next;
   logic [DATA_W-1:0] op_b_reg, op_b_next;
   logic [3:0]        opcode_reg, opcode_next;
   logic [CNT_W-1:0]  cnt_a_reg, cnt_a_next;
   logic [CNT_W-1:0]  cnt_b_reg, cnt_b_next;
   logic              calc_go_reg, calc_go_next;
   logic              div0_reg, div0_next;

   logic              is_digit, is_op, is_eq, is_bs, is_clr;
   logic [3:0]        digit_val;
   logic [3:0]        key_op;
   logic [EXT_W-1:0]  acc_a, acc_b;

   assign digit_val = rx_data[3:0];
   assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_eq     = (rx_data == 8'h3D) || (rx_data == 8'h0D);
   assign is_bs     = (rx_data == 8'h08) || (rx_data == 8'h7F);
   assign is_clr    = (rx_data == 8'h63) || (rx_data == 8'h43) || (rx_data == 8'h1B);

   // The digit limit keeps operand*10+d inside DATA_W, so truncation never loses bits.
   assign acc_a = EXT_W'(op_a_reg) * EXT_W'(10) + EXT_W'(digit_val);
   assign acc_b = EXT_W'(op_b_reg) * EXT_W'(10) + EXT_W'(digit_val);

   always_comb begin
      is_op  = 1'b1;
      key_op = 4'd0;
      case (rx_data)
         8'h2B:   key_op = 4'd0;
         8'h2D:   key_op = 4'd1;
         8'h2A:   key_op = 4'd2;
         8'h2F:   key_op = 4'd3;
         default: is_op = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ENTER_A;
         op_a_reg    <= '0;
         op_b_reg    <= '0;
         opcode_reg  <= '0;
         cnt_a_reg   <= '0;
         cnt_b_reg   <= '0;
         calc_go_reg <= 1'b0;
         div0_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         op_a_reg    <= op_a_next;
         op_b_reg    <= op_b_next;
         opcode_reg  <= opcode_next;
         cnt_a_reg   <= cnt_a_next;
         cnt_b_reg   <= cnt_b_next;
         calc_go_reg <= calc_go_next;
         div0_reg    <= div0_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      op_a_next    = op_a_reg;
      op_b_next    = op_b_reg;
      opcode_next  = opcode_reg;
      cnt_a_next   = cnt_a_reg;
      cnt_b_next   = cnt_b_reg;
      calc_go_next = 1'b0;

      if (rx_valid) begin
         if (is_clr) begin
            state_next  = ENTER_A;
            op_a_next   = '0;
            op_b_next   = '0;
            opcode_next = '0;
            cnt_a_next  = '0;
            cnt_b_next  = '0;
         end else if (is_digit) begin
            case (state_reg)
               ENTER_A: begin
                  if (cnt_a_reg < CNT_W'(MAX_DIGITS)) begin
                     op_a_next  = acc_a[DATA_W-1:0];
                     cnt_a_next = cnt_a_reg + CNT_W'(1);
                  end
               end
               ENTER_B: begin
                  if (cnt_b_reg < CNT_W'(MAX_DIGITS)) begin
                     op_b_next  = acc_b[DATA_W-1:0];
                     cnt_b_next = cnt_b_reg + CNT_W'(1);
                  end
               end
               default: begin
                  // A digit after a result or error begins a fresh calculation.
                  state_next  = ENTER_A;
                  op_a_next   = DATA_W'(digit_val);
                  op_b_next   = '0;
                  opcode_next = '0;
                  cnt_a_next  = CNT_W'(1);
                  cnt_b_next  = '0;
               end
            endcase
         end else if (is_op) begin
            if (state_reg == ENTER_A && cnt_a_reg != '0) begin
               opcode_next = key_op;
               state_next  = ENTER_B;
            end else if (state_reg == ENTER_B && cnt_b_reg == '0) begin
               opcode_next = key_op;
            end
         end else if (is_eq) begin
            if (state_reg == ENTER_B && cnt_b_reg != '0) begin
               if (opcode_reg == OP_DIV && op_b_reg == '0) begin
                  state_next = ERROR;
               end else begin
                  state_next   = RESULT;
                  calc_go_next = 1'b1;
               end
            end
         end else if (is_bs) begin
            if (state_reg == ENTER_A && cnt_a_reg != '0) begin
               op_a_next  = op_a_reg / DATA_W'(10);
               cnt_a_next = cnt_a_reg - CNT_W'(1);
            end else if (state_reg == ENTER_B) begin
               if (cnt_b_reg != '0) begin
                  op_b_next  = op_b_reg / DATA_W'(10);
                  cnt_b_next = cnt_b_reg - CNT_W'(1);
               end else begin
                  state_next = ENTER_A;
               end
            end
         end
      end

      div0_next = (state_next == ERROR);
   end

   assign op_a    = op_a_reg;
   assign op_b    = op_b_reg;
   assign opcode  = opcode_reg;
   assign state   = state_reg;
   assign calc_go = calc_go_reg;
   assign div0    = div0_reg;

`ifdef CALC_ECHO_EN
   logic [7:0] tx_data_reg;
   logic       tx_valid_reg;
   logic       key_effective;

   assign key_effective = rx_valid && ((state_next != state_reg) || (op_a_next != op_a_reg) ||
                                       (op_b_next != op_b_reg) || (opcode_next != opcode_reg));

   // Echo loads only into a free (or freeing) slot; otherwise it is dropped, never stalling parsing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data_reg  <= 8'h00;
         tx_valid_reg <= 1'b0;
      end else begin
         if (tx_valid_reg && tx_ready) begin
            tx_valid_reg <= 1'b0;
         end
         if (key_effective && (!tx_valid_reg || tx_ready)) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= rx_data;
         end
      end
   end

   assign tx_data  = tx_data_reg;
   assign tx_valid = tx_valid_reg;
`endif

endmodule

// File: tb/tb_calc_key_parser.sv
// Scoreboard bench for calc_key_parser: driver queues hand-computed results per key, monitor checks them.
module tb_calc_key_parser;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [15:0] op_a, op_b;
   logic [3:0]  opcode;
   logic [1:0]  state;
   logic        calc_go, div0;
`ifdef CALC_ECHO_EN
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
`endif

   calc_key_parser #(.DATA_W(16), .MAX_DIGITS(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .op_a     (op_a),
      .op_b     (op_b),
      .opcode   (opcode),
      .state    (state),
      .calc_go  (calc_go),
      .div0     (div0)
`ifdef CALC_ECHO_EN
      ,
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [1:0]  st;
      logic        go;
      logic        d0;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   go_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic key(input logic [7:0] b, input int a, input int bv, input int op,
                      input int st, input bit go);
      exp_t e;
      e.a  = 16'(a);
      e.b  = 16'(bv);
      e.op = 4'(op);
      e.st = 2'(st);
      e.go = go;
      e.d0 = (st == 3);
      exp_q.push_back(e);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Monitor: every accepted byte yields one updated output set on the following edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (rx_valid && reset_n) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("op_a", 32'(op_a), 32'(e.a));
               chk("op_b", 32'(op_b), 32'(e.b));
               chk("opcode", 32'(opcode), 32'(e.op));
               chk("state", 32'(state), 32'(e.st));
               chk("calc_go", 32'(calc_go), 32'(e.go));
               chk("div0", 32'(div0), 32'(e.d0));
               $display("key %02h -> a=%0d b=%0d op=%0d st=%0d go=%0b div0=%0b",
                        dut.rx_data, op_a, op_b, opcode, state, calc_go, div0);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (calc_go === 1'b1) go_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "timeout");
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_op_a"}, 32'(op_a), 32'd0);
      chk({tag, "_op_b"}, 32'(op_b), 32'd0);
      chk({tag, "_opcode"}, 32'(opcode), 32'd0);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_calc_go"}, 32'(calc_go), 32'd0);
      chk({tag, "_div0"}, 32'(div0), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;

      // "12+34=" plus ignored keys in RESULT
      key("1", 1, 0, 0, 0, 0);
      key("2", 12, 0, 0, 0, 0);
      key("+", 12, 0, 0, 1, 0);
      key("3", 12, 3, 0, 1, 0);
      key("4", 12, 34, 0, 1, 0);
      key("=", 12, 34, 0, 2, 1);
      key("+", 12, 34, 0, 2, 0);
      key("x", 12, 34, 0, 2, 0);

      // clear, then digit limit
      key("c", 0, 0, 0, 0, 0);
      key("9", 9, 0, 0, 0, 0);
      key("9", 99, 0, 0, 0, 0);
      key("9", 999, 0, 0, 0, 0);
      key("9", 9999, 0, 0, 0, 0);
      key("9", 9999, 0, 0, 0, 0);
      key(8'h1B, 0, 0, 0, 0, 0);

      // divide by zero, then recovery by a digit
      key("7", 7, 0, 0, 0, 0);
      key("/", 7, 0, 3, 1, 0);
      key("0", 7, 0, 3, 1, 0);
      key("=", 7, 0, 3, 3, 0);
      key("5", 5, 0, 0, 0, 0);

      // backspace and operator replacement
      key("C", 0, 0, 0, 0, 0);
      key("+", 0, 0, 0, 0, 0);
      key("1", 1, 0, 0, 0, 0);
      key("2", 12, 0, 0, 0, 0);
      key("3", 123, 0, 0, 0, 0);
      key(8'h08, 12, 0, 0, 0, 0);
      key("+", 12, 0, 0, 1, 0);
      key("-", 12, 0, 1, 1, 0);
      key(8'h7F, 12, 0, 1, 0, 0);
      key(8'h08, 1, 0, 1, 0, 0);
      key("=", 1, 0, 1, 0, 0);

      // nonzero divide, new calc from RESULT, CR as equals, '=' with empty B
      key("c", 0, 0, 0, 0, 0);
      key("8", 8, 0, 0, 0, 0);
      key("/", 8, 0, 3, 1, 0);
      key("2", 8, 2, 3, 1, 0);
      key("=", 8, 2, 3, 2, 1);
      key("3", 3, 0, 0, 0, 0);
      key("-", 3, 0, 1, 1, 0);
      key("1", 3, 1, 1, 1, 0);
      key(8'h0D, 3, 1, 1, 2, 1);
      key("5", 5, 0, 0, 0, 0);
      key("*", 5, 0, 2, 1, 0);
      key("=", 5, 0, 2, 1, 0);
      key(8'h1B, 0, 0, 0, 0, 0);

      // async reset mid-byte
      key("4", 4, 0, 0, 0, 0);
      key("5", 45, 0, 0, 0, 0);
      key("*", 45, 0, 2, 1, 0);
      @(negedge clk);
      rx_data  = "9";
      rx_valid = 1'b1;
      reset_n  = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      key("6", 6, 0, 0, 0, 0);

`ifdef CALC_ECHO_EN
      key(8'h1B, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("echo_drained", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;
      key("1", 1, 0, 0, 0, 0);
      key("2", 12, 0, 0, 0, 0);
      chk("echo_valid_held", 32'(tx_valid), 32'd1);
      chk("echo_data_held", 32'(tx_data), 32'h31);
      tx_ready = 1'b1;
      @(negedge clk);
      chk("echo_after_handshake", 32'(tx_valid), 32'd0);
      @(negedge clk);
      chk("echo_dropped_second", 32'(tx_valid), 32'd0);
`endif

      repeat (4) @(negedge clk);
      chk("calc_go_pulses", 32'(go_cnt), 32'd3);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
